// File: rtl/pipelined_sm_mult.sv
// ============================================================================
// Module      : pipelined_sm_mult
// Description : Three-stage sign-magnitude multiplier with an exact mode and
//               an approximate mode that drops the low product columns.
//               S1: partial products + 4:2 compressors.
//               S2: reduction down to two rows.
//               S3: carry-propagate add and output register.
//               Valid/ready handshake on both sides; bubbles are collapsed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_sm_mult #(
  parameter int W           = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           out_mode
);

  // Magnitude width, product-magnitude width, compressor groups and rows.
  localparam int M   = W - 1;
  localparam int PW  = 2 * M;
  localparam int NG  = (M + 3) / 4;
  localparam int NR  = 2 * NG;
  localparam int NPP = 4 * NG;

  // Carry-save adder on whole rows; the carry falling off the top is
  // harmless because the true product always fits in PW bits.
  function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] x,
                                          input logic [PW-1:0] y,
                                          input logic [PW-1:0] z);
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  // Stage handshake: each stage takes new data when empty or when drained.
  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic s1_acc_w, s2_acc_w, s3_acc_w;

  assign s3_acc_w = !s3_valid_q || out_ready;
  assign s2_acc_w = !s2_valid_q || s3_acc_w;
  assign s1_acc_w = !s1_valid_q || s2_acc_w;
  assign in_ready = s1_acc_w;

  // ---------------------------------------------------------------- S1 ----
  logic [NPP-1:0][PW-1:0] pp_w;
  logic [NR-1:0][PW-1:0]  s1_rows_d;
  logic [NR-1:0][PW-1:0]  s1_rows_q;
  logic                   s1_sign_q, s1_mode_q;
  logic [PW-1:0]          c42_s1, c42_c1, c42_s2, c42_c2;

  // Partial products, with low columns masked off in approximate mode so
  // nothing from them can ever carry upward.
  always_comb begin
    pp_w = '0;
    for (int r = 0; r < NPP; r++) begin
      if (r < M) begin
        for (int c = 0; c < M; c++) begin
          if (!(mode && ((r + c) < APPROX_COLS))) begin
            pp_w[r][r+c] = a[c] & b[r];
          end
        end
      end
    end
  end

  // Each group of four rows goes through one 4:2 compressor (two chained CSAs).
  always_comb begin
    s1_rows_d = '0;
    c42_s1    = '0;
    c42_c1    = '0;
    c42_s2    = '0;
    c42_c2    = '0;
    for (int g = 0; g < NG; g++) begin
      {c42_c1, c42_s1} = csa(pp_w[4*g], pp_w[4*g+1], pp_w[4*g+2]);
      {c42_c2, c42_s2} = csa(c42_s1, c42_c1, pp_w[4*g+3]);
      s1_rows_d[2*g]   = c42_s2;
      s1_rows_d[2*g+1] = c42_c2;
    end
  end

  // S1 register: captures operands' reduced rows, sign and mode together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_rows_q  <= '0;
      s1_sign_q  <= 1'b0;
      s1_mode_q  <= 1'b0;
    end else if (s1_acc_w) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_rows_q <= s1_rows_d;
        s1_sign_q <= a[W-1] ^ b[W-1];
        s1_mode_q <= mode;
      end
    end
  end

  // ---------------------------------------------------------------- S2 ----
  logic [PW-1:0] red_s_w, red_c_w;
  logic [PW-1:0] s2_s_q, s2_c_q;
  logic          s2_sign_q, s2_mode_q;

  // Fold the remaining compressor outputs into a single sum/carry pair.
  always_comb begin
    red_s_w = s1_rows_q[0];
    red_c_w = s1_rows_q[1];
    for (int i = 2; i < NR; i++) begin
      {red_c_w, red_s_w} = csa(red_s_w, red_c_w, s1_rows_q[i]);
    end
  end

  // S2 register: two-row redundant form of the magnitude.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_s_q     <= '0;
      s2_c_q     <= '0;
      s2_sign_q  <= 1'b0;
      s2_mode_q  <= 1'b0;
    end else if (s2_acc_w) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_s_q    <= red_s_w;
        s2_c_q    <= red_c_w;
        s2_sign_q <= s1_sign_q;
        s2_mode_q <= s1_mode_q;
      end
    end
  end

  // ---------------------------------------------------------------- S3 ----
  logic [PW-1:0]  mag_w;
  logic [2*W-1:0] p_d;

  // Final add; a zero magnitude never carries a sign.
  always_comb begin
    mag_w = s2_s_q + s2_c_q;
    p_d   = {s2_sign_q & (|mag_w), 1'b0, mag_w};
  end

  // S3 register: output holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid_q <= 1'b0;
      p          <= '0;
      out_mode   <= 1'b0;
    end else if (s3_acc_w) begin
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        p        <= p_d;
        out_mode <= s2_mode_q;
      end
    end
  end

  assign out_valid = s3_valid_q;

endmodule

`default_nettype wire

// File: doc/pipelined_sm_mult.md
PIPELINED_SM_MULT -- requirements
Module: pipelined_sm_mult

Interface
REQ-001 SHALL have parameter W, default 8: operand width, sign-magnitude (bit W-1 is the sign, bits W-2:0 are the magnitude); legal range 4..16.
REQ-002 SHALL have parameter APPROX_COLS, default 4: number of low product columns dropped in approximate mode; legal range 0..W-1.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operand pair and mode are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts an operand pair this cycle.
REQ-007 SHALL have port a, input, W bits: sign-magnitude multiplicand.
REQ-008 SHALL have port b, input, W bits: sign-magnitude multiplier.
REQ-009 SHALL have port mode, input, 1 bit: 0 = exact, 1 = approximate.
REQ-010 SHALL have port out_valid, output, 1 bit: p and out_mode hold a result.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-012 SHALL have port p, output, 2W bits: sign-magnitude product.
REQ-013 SHALL have port out_mode, output, 1 bit: the mode that produced p.

Function
REQ-014 SHALL accept an operand pair only on a cycle with in_valid=1 and in_ready=1, capturing a, b and mode together.
REQ-015 SHALL pass each result through a 3-stage pipeline: S1 forms partial products and reduces them with 4:2 compressors; S2 finishes reduction to two rows; S3 runs the final carry-propagate add and holds the output register.
REQ-016 SHALL present a result on out_valid exactly 3 cycles after acceptance when no stall occurs; sustained throughput SHALL be 1 result per cycle.
REQ-017 SHALL form the magnitude as the unsigned product of a[W-2:0] and b[W-2:0], placed in p[2W-3:0], with p[2W-2] always 0.
REQ-018 SHALL set p[2W-1] = a[W-1] XOR b[W-1], except that p[2W-1] SHALL be 0 when the magnitude of p is 0 (no negative zero).
REQ-019 In exact mode (mode=0) the magnitude SHALL be bit-exact for all operand pairs.
REQ-020 In approximate mode (mode=1) every partial-product bit in columns 0..APPROX_COLS-1 SHALL be zeroed before reduction, and p[APPROX_COLS-1:0] SHALL be 0; higher columns SHALL carry no carry from the dropped columns.
REQ-021 SHALL carry mode through the pipeline with its data, so results from mixed-mode back-to-back inputs are each correct for their own mode.
REQ-022 SHALL advance stage k when stage k is empty or stage k+1 is accepting; S3 SHALL accept when it is empty or out_ready=1.
REQ-023 in_ready SHALL equal (S1 empty) OR (S1 advancing), so internal bubbles are collapsed.
REQ-024 While out_valid=1 and out_ready=0, p, out_mode and out_valid SHALL stay stable.
REQ-025 SHALL drop no result and duplicate no result under any out_ready pattern; results SHALL leave in acceptance order.
REQ-026 When out_ready=1 and a new input is accepted in the same cycle with the pipeline full, both SHALL complete in that cycle.
REQ-027 SHALL produce no X on any output after reset, including when W-bit operands are all 0 or all 1.

Reset
REQ-028 Asserting rst SHALL immediately clear all stage valid flags, force out_valid=0, p=0, out_mode=0 and in_ready=1, and discard every in-flight operation.
REQ-029 On the first rising clk edge after rst deasserts, the block SHALL accept a new operand pair.

Verification
REQ-030 W=8, exact: a=0x85, b=0x03 -> 3 cycles later p=0x800F, out_mode=0.
REQ-031 W=8, exact: a=0x7F, b=0xFF -> p=0xBF01 (magnitude 16129, sign set).
REQ-032 W=8, APPROX_COLS=4, mode=1: a=0x85, b=0x03 -> p=0x0000 (all columns dropped, sign forced 0); a=0x7F, b=0x7F -> p[3:0]=0 and p is no greater than 0x3F01.
REQ-033 Backpressure: 6 back-to-back inputs with out_ready=0 for 8 cycles -> in_ready drops after 3 accepts, p holds stable, and all 6 results emerge in order once out_ready=1.
REQ-034 Reset mid-operation: rst pulsed with 3 results in flight -> out_valid=0 at once, no stale result ever appears, and the next input's result appears 3 cycles after acceptance.
REQ-035 Random regression: 10^5 random W=8 and W=12 operand pairs with random modes and random out_ready -> every output matches a reference model.
